// File: rtl/demultiplexor_reg_if.sv
// Bus bundle for the registered stream demultiplexor: one producer-side
// stream in, two independent consumer-side streams out, plus counters.
//
// Handshake: a word moves on a rising clock edge only when the side
// holding it raises valid and the side taking it raises ready in the same
// cycle. Valid never waits on ready. While valid is high and the word has
// not been taken, the sender keeps data (and sel) stable.
interface demultiplexor_reg_if #(
  parameter int WIDTH     = 5,
  parameter int CNT_WIDTH = 8
);
  logic                 sel;
  logic                 in_valid;
  logic [WIDTH-1:0]     in_data;
  logic                 in_ready;
  logic                 out0_valid;
  logic [WIDTH-1:0]     out0_data;
  logic                 out0_ready;
  logic                 out1_valid;
  logic [WIDTH-1:0]     out1_data;
  logic                 out1_ready;
  logic [CNT_WIDTH-1:0] cnt0;
  logic [CNT_WIDTH-1:0] cnt1;

  // Block side: consumes the input stream, drives both output streams.
  modport slave (
    input  sel, in_valid, in_data, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1
  );

  // Environment side: producer plus both consumers.
  modport master (
    output sel, in_valid, in_data, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1
  );
endinterface

// File: rtl/demultiplexor_reg.sv
// Registered stream demultiplexor. Each input word is steered by sel into
// one of two single-entry holding registers; each channel has its own
// valid/ready handshake and a wrapping count of words accepted into it.
// A full channel that is being drained in the same cycle still accepts a
// new word, so a continuously-ready consumer sees one word per cycle.
module demultiplexor_reg #(
  parameter int WIDTH     = 5,
  parameter int CNT_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  demultiplexor_reg_if.slave bus,
  output logic [1:0]         dbg_state_o   // bit c is 1 when channel c is FULL
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chan_state_e;

  chan_state_e          state_q [2];
  chan_state_e          state_d [2];
  logic [WIDTH-1:0]     data_q  [2];
  logic [WIDTH-1:0]     data_d  [2];
  logic [CNT_WIDTH-1:0] cnt_q   [2];
  logic [CNT_WIDTH-1:0] cnt_d   [2];

  logic [1:0] out_ready;
  logic [1:0] chan_ready;
  logic [1:0] push;
  logic [1:0] pop;
  logic       in_ready;

  assign out_ready = {bus.out1_ready, bus.out0_ready};

  // Readiness, acceptance and drain strobes. Push is qualified by in_valid
  // first so an unknown sel while idle cannot reach the channel state.
  always_comb begin
    chan_ready = '0;
    push       = '0;
    pop        = '0;
    for (int c = 0; c < 2; c++) begin
      chan_ready[c] = (state_q[c] == EMPTY) || out_ready[c];
      pop[c]        = (state_q[c] == FULL) && out_ready[c];
    end
    in_ready = bus.sel ? chan_ready[1] : chan_ready[0];
    push[0]  = bus.in_valid && in_ready && (bus.sel == 1'b0);
    push[1]  = bus.in_valid && in_ready && (bus.sel == 1'b1);
  end

  // Per-channel next state: load on push, empty on pop without push,
  // otherwise hold. Data is kept after a pop so the last word stays visible.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      state_d[c] = state_q[c];
      data_d[c]  = data_q[c];
      cnt_d[c]   = cnt_q[c];
      case (state_q[c])
        EMPTY: begin
          if (push[c]) begin
            state_d[c] = FULL;
            data_d[c]  = bus.in_data;
          end
        end
        FULL: begin
          if (push[c]) begin
            data_d[c] = bus.in_data;
          end else if (pop[c]) begin
            state_d[c] = EMPTY;
          end
        end
        default: state_d[c] = EMPTY;
      endcase
      if (push[c]) begin
        cnt_d[c] = cnt_q[c] + 1'b1;
      end
    end
  end

  // Channel registers; reset discards any buffered word immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        state_q[c] <= EMPTY;
        data_q[c]  <= '0;
        cnt_q[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        state_q[c] <= state_d[c];
        data_q[c]  <= data_d[c];
        cnt_q[c]   <= cnt_d[c];
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out0_valid = (state_q[0] == FULL);
  assign bus.out1_valid = (state_q[1] == FULL);
  assign bus.out0_data  = data_q[0];
  assign bus.out1_data  = data_q[1];
  assign bus.cnt0       = cnt_q[0];
  assign bus.cnt1       = cnt_q[1];
  assign dbg_state_o    = {state_q[1] == FULL, state_q[0] == FULL};

endmodule

// File: tb/tb_demultiplexor_reg.sv
// Directed bench for demultiplexor_reg: reset, steering, backpressure,
// channel isolation, asynchronous reset mid-operation, streaming with
// counter wrap. Inputs change on the falling edge, outputs are checked
// on the falling edge (or 1 ns after an input change for comb paths).
module tb_demultiplexor_reg;
  localparam int WIDTH     = 5;
  localparam int CNT_WIDTH = 8;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         n_cmp;
  int         n_err;

  demultiplexor_reg_if #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

  demultiplexor_reg #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Full snapshot of both channels
  task automatic check_chan(input string tag,
                            input logic v0, input logic [WIDTH-1:0] d0, input logic [7:0] c0,
                            input logic v1, input logic [WIDTH-1:0] d1, input logic [7:0] c1);
    check({tag, ".v0"},  32'(bus.out0_valid), 32'(v0));
    check({tag, ".d0"},  32'(bus.out0_data),  32'(d0));
    check({tag, ".c0"},  32'(bus.cnt0),       32'(c0));
    check({tag, ".v1"},  32'(bus.out1_valid), 32'(v1));
    check({tag, ".d1"},  32'(bus.out1_data),  32'(d1));
    check({tag, ".c1"},  32'(bus.cnt1),       32'(c1));
    check({tag, ".dbg"}, 32'(dbg_state),      32'({v1, v0}));
  endtask

  // Driver
  task automatic drive(input logic v, input logic s, input logic [WIDTH-1:0] d,
                       input logic r0, input logic r1);
    bus.in_valid   = v;
    bus.sel        = s;
    bus.in_data    = d;
    bus.out0_ready = r0;
    bus.out1_ready = r1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 5'h00, 1'b0, 1'b0);

    // Reset and idle
    repeat (2) @(negedge clk);
    check_chan("rst_hold", 0, 5'h00, 8'd0, 0, 5'h00, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_chan("idle", 0, 5'h00, 8'd0, 0, 5'h00, 8'd0);
    check("idle.in_ready", 32'(bus.in_ready), 32'd1);

    // Basic steering
    drive(1'b1, 1'b0, 5'h15, 1'b0, 1'b0);
    #1 check("steer0.in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    check_chan("steer0", 1, 5'h15, 8'd1, 0, 5'h00, 8'd0);
    drive(1'b1, 1'b1, 5'h0A, 1'b0, 1'b0);
    #1 check("steer1.in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    check_chan("steer1", 1, 5'h15, 8'd1, 1, 5'h0A, 8'd1);

    // Backpressure on channel 0
    drive(1'b1, 1'b0, 5'h0A, 1'b0, 1'b0);
    #1 check("bp.in_ready_lo", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check_chan("bp.stall", 1, 5'h15, 8'd1, 1, 5'h0A, 8'd1);
    bus.out0_ready = 1'b1;
    #1 check("bp.in_ready_hi", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    check_chan("bp.refill", 1, 5'h0A, 8'd2, 1, 5'h0A, 8'd1);

    // Drain channel 1 alone; its data must hold after the pop
    drive(1'b0, 1'b0, 5'h00, 1'b0, 1'b1);
    @(negedge clk);
    check_chan("drain1", 1, 5'h0A, 8'd2, 0, 5'h0A, 8'd1);

    // Isolation: channel 0 stalled, channel 1 keeps accepting
    drive(1'b1, 1'b1, 5'h1F, 1'b0, 1'b0);
    #1 check("iso.in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    check_chan("iso", 1, 5'h0A, 8'd2, 1, 5'h1F, 8'd2);
    drive(1'b0, 1'b0, 5'h00, 1'b0, 1'b0);
    #1 check("iso.sel0_blocked", 32'(bus.in_ready), 32'd0);
    // Ready on an empty channel is ignored; X sel while idle is harmless
    drive(1'b0, 1'bx, 5'h03, 1'b0, 1'b0);
    @(negedge clk);
    check_chan("idle_x", 1, 5'h0A, 8'd2, 1, 5'h1F, 8'd2);

    // One more word into channel 0 (full-through: pop and push together)
    drive(1'b1, 1'b0, 5'h07, 1'b1, 1'b0);
    @(negedge clk);
    check_chan("push3", 1, 5'h07, 8'd3, 1, 5'h1F, 8'd2);

    // Asynchronous reset between edges
    drive(1'b0, 1'b0, 5'h00, 1'b0, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_chan("async_rst", 0, 5'h00, 8'd0, 0, 5'h00, 8'd0);
    check("async_rst.in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Streaming 256 words into channel 1 with its consumer always ready
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 1'b1, 5'(i % 32), 1'b0, 1'b1);
      #1 check($sformatf("strm%0d.in_ready", i), 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      check($sformatf("strm%0d.v1", i), 32'(bus.out1_valid), 32'd1);
      check($sformatf("strm%0d.d1", i), 32'(bus.out1_data),  32'(i % 32));
      check($sformatf("strm%0d.c1", i), 32'(bus.cnt1),       32'((i + 1) % 256));
    end
    drive(1'b0, 1'b1, 5'h00, 1'b0, 1'b1);
    @(negedge clk);
    check_chan("strm_end", 0, 5'h00, 8'd0, 0, 5'h1F, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
